// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types and constants for the two-input stream selector.
//   src_t          - 1-bit channel index (0 = in0, 1 = in1)
//   DEFAULT_WIDTH  - default data width
//   PRIO_LAST_RST  - reset value of the last-winner register (1 => channel 0 wins first conflict)
//   SEL_RST        - reset value of the held mux select
package stream_mux_pkg;
   typedef logic src_t;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam src_t        PRIO_LAST_RST = 1'b1;
   localparam src_t        SEL_RST       = 1'b0;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-request round-robin arbiter.
// Ports:
//   req[1:0]   - request per channel
//   prio_last  - last winning channel
//   lock       - hold the grant on the previously selected channel
//   hold_sel   - previous grant, kept when idle or locked
//   accept     - downstream register can take a word this cycle
//   acc_last   - last flag of the granted channel's word
//   grant      - combinational grant index
//   prio_next  - next value of prio_last
// Parameter LOCK_EN: when set, prio_last only advances on packet-final beats.
module rr_arb2
   import stream_mux_pkg::*;
#(
   parameter bit LOCK_EN = 1'b0
) (
   input  logic [1:0] req,
   input  src_t       prio_last,
   input  logic       lock,
   input  src_t       hold_sel,
   input  logic       accept,
   input  logic       acc_last,
   output src_t       grant,
   output src_t       prio_next
);

   logic beat;

   always_comb begin
      grant = hold_sel;
      if (!lock) begin
         unique case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~prio_last;
            default: grant = hold_sel;
         endcase
      end
   end

   assign beat = accept & req[grant];

   always_comb begin
      prio_next = prio_last;
      if (beat && (!LOCK_EN || acc_last))
         prio_next = grant;
   end

endmodule

// File: rtl/stream_mux2_arb.sv
// stream_mux2_arb: two-input valid/ready stream selector with a registered output.
// Arbitrates between in0 and in1 (round-robin on conflict), drives the mux select
// and holds the selected word in an output register with backpressure.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   in0_valid/in0_data/in0_last     - channel 0 stream in; in0_ready accepted this cycle
//   in1_valid/in1_data/in1_last     - channel 1 stream in; in1_ready accepted this cycle
//   out_valid/out_data/out_last     - registered output word
//   out_src                         - source channel of the registered word
//   out_ready                       - consumer accepts the output word
//   sel                             - combinational grant index (mux select)
// Build option: define STREAM_MUX2_LOCK_EN to keep the grant on one channel
// until that channel's packet-final (last) beat has been accepted.
module stream_mux2_arb
   import stream_mux_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in0_last,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_last,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_src,
   input  logic             out_ready,
   output logic             sel
);

`ifdef STREAM_MUX2_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic load;
   logic accept;
   logic sel_last;
   src_t grant;
   src_t sel_q;
   src_t prio_last;
   src_t prio_next;
   logic lock;

   assign load = out_ready | ~out_valid;

   rr_arb2 #(
      .LOCK_EN (LOCK_EN)
   ) u_arb (
      .req       ({in1_valid, in0_valid}),
      .prio_last (prio_last),
      .lock      (lock),
      .hold_sel  (sel_q),
      .accept    (load),
      .acc_last  (sel_last),
      .grant     (grant),
      .prio_next (prio_next)
   );

   assign sel       = grant;
   assign in0_ready = load & (grant == 1'b0);
   assign in1_ready = load & (grant == 1'b1);
   assign accept    = load & (grant ? in1_valid : in0_valid);
   assign sel_last  = grant ? in1_last : in0_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= 1'b0;
         sel_q     <= SEL_RST;
         prio_last <= PRIO_LAST_RST;
      end else begin
         sel_q     <= grant;
         prio_last <= prio_next;
         if (load)
            out_valid <= accept;
         if (accept) begin
            out_data <= grant ? in1_data : in0_data;
            out_last <= sel_last;
            out_src  <= grant;
         end
      end
   end

`ifdef STREAM_MUX2_LOCK_EN
   // Lock follows every accepted beat: set on a non-final word, cleared on the final one.
   always_ff @(posedge clk) begin
      if (rst)
         lock <= 1'b0;
      else if (accept)
         lock <= ~sel_last;
   end
`else
   assign lock = 1'b0;
`endif

endmodule
